// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB init sequencer.
//   sccb_state_t   : sequencer FSM states
//   SCCB_END       : table terminator entry
//   SCCB_DELAY_TAG : sub-address that marks a delay entry
//   sccb_entry_t   : one 16-bit table entry {addr, val}
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        WR_REQ,
        WR_WAIT,
        RELEASE,
        RD_REQ,
        RD_WAIT,
        CHECK,
        DELAY,
        FIN,
        ERR
    } sccb_state_t;

    localparam logic [15:0] SCCB_END       = 16'hFFFF;
    localparam logic [7:0]  SCCB_DELAY_TAG = 8'hF0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } sccb_entry_t;

endpackage

// File: rtl/sccb_init_rom.sv
// Camera register table, synchronous-read case ROM.
// The entry addressed in one cycle appears on rom_data in the next.
// Ports:
//   XCLK     in  : system clock
//   addr     in  : table index
//   rom_data out : registered {sub_addr, value} entry; unused slots read SCCB_END
module sccb_init_rom
    import sccb_pkg::*;
#(
    parameter int ROM_DEPTH = 64
) (
    input  logic                         XCLK,
    input  logic [$clog2(ROM_DEPTH)-1:0] addr,
    output logic [15:0]                  rom_data
);

    function automatic logic [15:0] rom_lookup(input int a);
        case (a)
            0:       rom_lookup = 16'h1280;   // COM7: soft reset
            1:       rom_lookup = 16'h1101;   // CLKRC: prescaler
            2:       rom_lookup = 16'hF003;   // settle 3 ticks after reset
            3:       rom_lookup = 16'h1204;   // COM7: RGB output
            4:       rom_lookup = 16'h40D0;   // COM15: full range RGB565
            5:       rom_lookup = 16'h3A04;   // TSLB: output sequence
            6:       rom_lookup = 16'hF000;   // zero-length pause
            default: rom_lookup = SCCB_END;
        endcase
    endfunction

    always_ff @(posedge XCLK) begin
        rom_data <= rom_lookup(int'(addr));
    end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the camera register table and drives the SCCB master with one
// 3-phase write per entry, optionally followed by a read-back check.
// Ports:
//   XCLK, RST_N        : clock, asynchronous active-low reset
//   go                 : rising edge starts the table from index 0
//   sccb_mid_pulse     : one-cycle strobe shared with the SCCB master
//   start, rw, ip_addr, sub_addr, data_in : transaction request to the master
//   done, data_out     : completion and read-back byte from the master
//   busy, init_done, error, index, mismatch_cnt : sequence status
module sccb_init_sequencer
    import sccb_pkg::*;
#(
    parameter logic [7:0] ID_ADDR        = 8'h42,
    parameter int         ROM_DEPTH      = 64,
    parameter int         DELAY_UNIT     = 25000,
    parameter int         VERIFY         = 1,
    parameter int         RETRIES        = 2,
    parameter int         TIMEOUT_PULSES = 128
) (
    input  logic                         XCLK,
    input  logic                         RST_N,
    input  logic                         go,
    input  logic                         sccb_mid_pulse,
    output logic                         start,
    output logic                         rw,
    output logic [7:0]                   ip_addr,
    output logic [7:0]                   sub_addr,
    output logic [7:0]                   data_in,
    input  logic                         done,
    input  logic [7:0]                   data_out,
    output logic                         busy,
    output logic                         init_done,
    output logic                         error,
    output logic [$clog2(ROM_DEPTH)-1:0] index,
    output logic [7:0]                   mismatch_cnt
);

    localparam int IDX_W   = $clog2(ROM_DEPTH);
    localparam int UNIT_W  = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam int TO_W    = (TIMEOUT_PULSES > 1) ? $clog2(TIMEOUT_PULSES) : 1;
    localparam int RETRY_W = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    sccb_state_t        state, state_nxt;
    logic               go_q;
    logic               go_rise;
    logic [15:0]        rom_data;
    sccb_entry_t        rom_entry;

    logic               start_nxt, rw_nxt, busy_nxt, init_done_nxt, error_nxt;
    logic [7:0]         ip_addr_nxt, sub_addr_nxt, data_in_nxt, mismatch_nxt;
    logic [IDX_W-1:0]   index_nxt;
    logic [7:0]         rd_data, rd_data_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [TO_W-1:0]    to_cnt, to_nxt;
    logic               rel_cnt, rel_nxt;
    logic               after_rd, after_rd_nxt;
    logic [UNIT_W-1:0]  unit_cnt, unit_nxt;
    logic [7:0]         tick_cnt, tick_nxt;
    logic               adv;

    sccb_init_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
        .XCLK     (XCLK),
        .addr     (index),
        .rom_data (rom_data)
    );

    assign rom_entry = sccb_entry_t'(rom_data);
    assign go_rise   = go & ~go_q;

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            go_q         <= 1'b1;   // a go held high through reset is not an edge
            start        <= 1'b0;
            rw           <= 1'b0;
            ip_addr      <= ID_ADDR;
            sub_addr     <= 8'h00;
            data_in      <= 8'h00;
            busy         <= 1'b0;
            init_done    <= 1'b0;
            error        <= 1'b0;
            index        <= '0;
            mismatch_cnt <= 8'h00;
            rd_data      <= 8'h00;
            retry_cnt    <= '0;
            to_cnt       <= '0;
            rel_cnt      <= 1'b0;
            after_rd     <= 1'b0;
            unit_cnt     <= '0;
            tick_cnt     <= 8'h00;
        end else begin
            state        <= state_nxt;
            go_q         <= go;
            start        <= start_nxt;
            rw           <= rw_nxt;
            ip_addr      <= ip_addr_nxt;
            sub_addr     <= sub_addr_nxt;
            data_in      <= data_in_nxt;
            busy         <= busy_nxt;
            init_done    <= init_done_nxt;
            error        <= error_nxt;
            index        <= index_nxt;
            mismatch_cnt <= mismatch_nxt;
            rd_data      <= rd_data_nxt;
            retry_cnt    <= retry_nxt;
            to_cnt       <= to_nxt;
            rel_cnt      <= rel_nxt;
            after_rd     <= after_rd_nxt;
            unit_cnt     <= unit_nxt;
            tick_cnt     <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        start_nxt     = start;
        rw_nxt        = rw;
        ip_addr_nxt   = ip_addr;
        sub_addr_nxt  = sub_addr;
        data_in_nxt   = data_in;
        busy_nxt      = busy;
        init_done_nxt = init_done;
        error_nxt     = error;
        index_nxt     = index;
        mismatch_nxt  = mismatch_cnt;
        rd_data_nxt   = rd_data;
        retry_nxt     = retry_cnt;
        to_nxt        = to_cnt;
        rel_nxt       = rel_cnt;
        after_rd_nxt  = after_rd;
        unit_nxt      = unit_cnt;
        tick_nxt      = tick_cnt;
        adv           = 1'b0;

        case (state)
            IDLE, FIN, ERR: begin
                if (go_rise) begin
                    index_nxt     = '0;
                    init_done_nxt = 1'b0;
                    error_nxt     = 1'b0;
                    mismatch_nxt  = 8'h00;
                    busy_nxt      = 1'b1;
                    state_nxt     = FETCH;
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                retry_nxt = '0;
                if (rom_entry == SCCB_END) begin
                    init_done_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    state_nxt     = FIN;
                end else if (rom_entry.addr == SCCB_DELAY_TAG) begin
                    tick_nxt  = rom_entry.val;
                    unit_nxt  = '0;
                    state_nxt = DELAY;
                end else begin
                    // Request fields settle here, a cycle ahead of start.
                    sub_addr_nxt = rom_entry.addr;
                    data_in_nxt  = rom_entry.val;
                    rw_nxt       = 1'b0;
                    ip_addr_nxt  = ID_ADDR;
                    state_nxt    = WR_REQ;
                end
            end
            WR_REQ: begin
                start_nxt    = 1'b1;
                to_nxt       = '0;
                after_rd_nxt = 1'b0;
                state_nxt    = WR_WAIT;
            end
            RD_REQ: begin
                start_nxt    = 1'b1;
                to_nxt       = '0;
                after_rd_nxt = 1'b1;
                state_nxt    = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                if (done) begin
                    start_nxt = 1'b0;
                    rel_nxt   = 1'b0;
                    if (state == RD_WAIT) rd_data_nxt = data_out;
                    state_nxt = RELEASE;
                end else if (sccb_mid_pulse) begin
                    if (to_cnt == TO_W'(TIMEOUT_PULSES - 1)) begin
                        start_nxt = 1'b0;
                        error_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ERR;
                    end else begin
                        to_nxt = to_cnt + TO_W'(1);
                    end
                end
            end
            RELEASE: begin
                // Two mid pulses with done low guarantee the bus is idle.
                if (done) begin
                    rel_nxt = 1'b0;
                end else if (sccb_mid_pulse) begin
                    if (rel_cnt) begin
                        if (after_rd) begin
                            state_nxt = CHECK;
                        end else if (VERIFY != 0) begin
                            rw_nxt      = 1'b1;
                            ip_addr_nxt = ID_ADDR | 8'h01;
                            state_nxt   = RD_REQ;
                        end else begin
                            adv = 1'b1;
                        end
                    end else begin
                        rel_nxt = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (rd_data == data_in) begin
                    adv = 1'b1;
                end else begin
                    if (mismatch_cnt != 8'hFF) mismatch_nxt = mismatch_cnt + 8'h01;
                    if (retry_cnt < RETRY_W'(RETRIES)) begin
                        retry_nxt   = retry_cnt + RETRY_W'(1);
                        rw_nxt      = 1'b0;
                        ip_addr_nxt = ID_ADDR;
                        state_nxt   = WR_REQ;
                    end else begin
                        error_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ERR;
                    end
                end
            end
            DELAY: begin
                // Stays exactly value*DELAY_UNIT cycles; a zero value leaves at once.
                if ((tick_cnt == 8'h00) ||
                    ((tick_cnt == 8'h01) && (unit_cnt == UNIT_W'(DELAY_UNIT - 1)))) begin
                    adv = 1'b1;
                end else if (unit_cnt == UNIT_W'(DELAY_UNIT - 1)) begin
                    unit_nxt = '0;
                    tick_nxt = tick_cnt - 8'h01;
                end else begin
                    unit_nxt = unit_cnt + UNIT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The last table slot finishes the sequence instead of wrapping.
        if (adv) begin
            if (index == IDX_W'(ROM_DEPTH - 1)) begin
                init_done_nxt = 1'b1;
                busy_nxt      = 1'b0;
                state_nxt     = FIN;
            end else begin
                index_nxt = index + IDX_W'(1);
                state_nxt = FETCH;
            end
        end
    end

endmodule

// File: doc/sccb_init_sequencer.md
# sccb_init_sequencer

Upstream command source for the 2-wire SCCB master. Walks a table of camera register writes stored in a ROM and issues each as a 3-phase write to the SCCB master. Each write can be read back with a 2-phase write / 2-phase read pair and checked against the table value. Runs once per `go` request, typically once after power-up, so that the camera is configured before pixel capture is enabled.

## Interface
- `ID_ADDR`, 8'h42: camera device ID, write form; bit 0 must be 0.
- `ROM_DEPTH`, 64: table entries; index width is clog2(ROM_DEPTH).
- `DELAY_UNIT`, 25000: XCLK cycles per delay tick (1 ms at 25 MHz).
- `VERIFY`, 1: 1 = read back and compare after every write.
- `RETRIES`, 2: re-attempts per entry after a mismatch.
- `TIMEOUT_PULSES`, 128: SCCB mid pulses allowed while waiting for `done`.
- `XCLK` in 1: system clock, same as the SCCB master.
- `RST_N` in 1: asynchronous, active-low reset.
- `go` in 1: rising edge starts the table from index 0.
- `sccb_mid_pulse` in 1: one-XCLK strobe, shared with the SCCB master.
- `start` out 1: transaction request to the master.
- `rw` out 1: 0 = 3-phase write, 1 = 2-phase write + 2-phase read.
- `ip_addr` out 8: ID_ADDR for writes, ID_ADDR|1 for reads.
- `sub_addr` out 8: register address.
- `data_in` out 8: register write value.
- `done` in 1: transaction complete from the master; held while `start` is high.
- `data_out` in 8: read-back byte from the master.
- `busy` out 1: sequence in progress.
- `init_done` out 1: table finished with no error; sticky until the next `go`.
- `error` out 1: timeout or retries exhausted; sticky until the next `go`.
- `index` out clog2(ROM_DEPTH): current or failing entry.
- `mismatch_cnt` out 8: total read-back mismatches; saturates at 255.

## Operation
- Entry format is 16 bits, `{sub_addr, value}`.
- 16'hFFFF marks the end of the table.
- `sub_addr` 8'hF0 marks a delay entry: wait `value` × DELAY_UNIT cycles. A value of 0 is a 0-tick delay.
- Every other entry is a register write.
- FSM states: IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, RELEASE, RD_REQ, RD_WAIT, CHECK, DELAY, FIN, ERR.
- IDLE, FIN and ERR: a `go` rising edge clears index, status and `mismatch_cnt`, then goes to FETCH.
- FETCH: present the ROM address; data is valid one cycle later. Then DECODE.
- DECODE:
  - end marker → FIN;
  - delay entry → DELAY;
  - otherwise load `sub_addr`/`data_in`, set `rw`=0 and `ip_addr`=ID_ADDR → WR_REQ.
- WR_REQ: assert `start` → WR_WAIT.
- WR_WAIT: hold `start` until `done`=1, then deassert `start` → RELEASE.
- RELEASE:
  - wait for `done`=0, then 2 further `sccb_mid_pulse` strobes with `start` low (guaranteed bus idle);
  - after a write: RD_REQ if VERIFY, otherwise advance;
  - after a read: CHECK.
- RD_REQ: `rw`=1, `ip_addr`=ID_ADDR|1, assert `start` → RD_WAIT.
- RD_WAIT: same handshake as WR_WAIT; latch `data_out` in the cycle `done` is first seen high.
- CHECK:
  - match → advance;
  - mismatch → `mismatch_cnt`+1; retry the entry from WR_REQ if the retry count < RETRIES, otherwise ERR.
- Advance: index+1 → FETCH. If index is already ROM_DEPTH-1 → FIN; no wrap.
- DELAY: count DELAY_UNIT × value XCLK cycles → advance.
- Timeout: `sccb_mid_pulse` strobes are counted in WR_WAIT/RD_WAIT. Reaching TIMEOUT_PULSES → ERR; `start` drops in the same cycle.
- FIN: `init_done`=1, `busy`=0. ERR: `error`=1, `busy`=0, `index` frozen on the failing entry.

## Timing
- All outputs are registered.
- Reset values:
  - `start`=0, `rw`=0, `ip_addr`=ID_ADDR, `sub_addr`=0, `data_in`=0;
  - `busy`=0, `init_done`=0, `error`=0, `index`=0, `mismatch_cnt`=0.
- `busy` rises in the cycle after the `go` edge.
- `sub_addr`, `data_in`, `rw` and `ip_addr` are stable at least 1 cycle before `start` rises and for as long as `start` is high.
- Done-to-start-low is 1 XCLK cycle.
- Minimum gap between transactions is 2 `sccb_mid_pulse` periods after `done` falls.
- `go` edges while `busy`=1 are ignored.
- A `done` that is already high on entry to WR_WAIT/RD_WAIT without a fresh request cannot occur, because RELEASE guarantees `done`=0 first.
- Reset mid-transaction: `start` drops asynchronously; the master's own reset restores its idle state. After reset, the sequencer waits for a new `go` edge.

## Structure
- Package `sccb_pkg`:
  - state enum;
  - constants SCCB_END=16'hFFFF and SCCB_DELAY_TAG=8'hF0;
  - entry typedef `{logic [7:0] addr; logic [7:0] val;}`.
- Sub-module `sccb_init_rom`: synchronous-read case ROM of camera settings with registered 1-cycle output, ROM_DEPTH entries, unused entries = SCCB_END.
- The FSM, delay counter, timeout counter and retry counter live in the top module.

## Test plan
- ROM {12'h80 write, 11'h01, FFFF}, VERIFY=0, behavioural master that raises `done` 60 pulses after `start` → exactly 2 writes with `ip_addr`=8'h42 and `rw`=0, then `init_done`=1 and `index`=2.
- VERIFY=1, master echoes written data → per entry one write then one read with `ip_addr`=8'h43 and `rw`=1; `mismatch_cnt`=0; `init_done`=1.
- Master returns 8'h00 for reg 12 (wrote 8'h80), RETRIES=2 → 3 write/read pairs, then `error`=1, `index`=0, `mismatch_cnt`=3, `start`=0.
- Entry F0_03 with DELAY_UNIT=10 → no `start` for exactly 30 cycles, then the next entry is issued.
- Master never asserts `done` → `start` drops after 128 mid pulses, `error`=1.
- `RST_N` pulsed low during WR_WAIT → `start`=0 immediately and all outputs at reset values. A new `go` edge restarts at index 0; the table's first entry being FFFF gives `init_done`=1 with no transaction.
